// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: function codes, result-register
// state encoding and the reserved-code check.
package alu_pkg;

  localparam logic [3:0] FUN_ADD  = 4'h0;
  localparam logic [3:0] FUN_SUB  = 4'h1;
  localparam logic [3:0] FUN_SHL  = 4'h2;
  localparam logic [3:0] FUN_SHR  = 4'h3;
  localparam logic [3:0] FUN_AND  = 4'h8;
  localparam logic [3:0] FUN_OR   = 4'h9;
  localparam logic [3:0] FUN_NOT  = 4'hA;
  localparam logic [3:0] FUN_XOR  = 4'hB;
  localparam logic [3:0] FUN_NAND = 4'hC;
  localparam logic [3:0] FUN_NOR  = 4'hD;
  localparam logic [3:0] FUN_XNOR = 4'hE;
  localparam logic [3:0] FUN_EQ   = 4'hF;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Codes 4..7 are reserved: accepted, but flagged and produce zero.
  function automatic logic fun_is_illegal(input logic [3:0] fun);
    return (fun[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both lanes; the arbiter feeds it the
// operands of whichever lane is granted.
module alu_core
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    fun,
  output logic [DW-1:0] data,
  output logic          zero,
  output logic          illegal
);

  // Shift amount is the whole of B, so anything >= DW clears the result.
  localparam logic [DW:0] DW_LIM = (DW+1)'(DW);

  logic shift_big_s;

  assign shift_big_s = ({1'b0, b} >= DW_LIM);
  assign illegal     = fun_is_illegal(fun);

  // Function decode; zero flag is only meaningful for the compare.
  always_comb begin
    data = {DW{1'b0}};
    zero = 1'b0;
    case (fun)
      FUN_ADD:  data = a + b;
      FUN_SUB:  data = a - b;
      FUN_SHL: begin
        if (shift_big_s) data = {DW{1'b0}};
        else             data = a << b;
      end
      FUN_SHR: begin
        if (shift_big_s) data = {DW{1'b0}};
        else             data = a >> b;
      end
      FUN_AND:  data = a & b;
      FUN_OR:   data = a | b;
      FUN_NOT:  data = ~a;
      FUN_XOR:  data = a ^ b;
      FUN_NAND: data = ~(a & b);
      FUN_NOR:  data = ~(a | b);
      FUN_XNOR: data = ~(a ^ b);
      FUN_EQ:   zero = (a == b);
      default:  data = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-lane round-robin arbiter in front of a single ALU with a one-deep
// registered result stage (EMPTY/FULL) and per-lane acceptance counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [3:0]    req0_fun,
  input  logic [TW-1:0] req0_tag,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req1_fun,
  input  logic [TW-1:0] req1_tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          res_lane,
  output logic [TW-1:0] res_tag,
  output logic          res_illegal,
  output logic [15:0]   ops_lane0,
  output logic [15:0]   ops_lane1
);

  state_e        state_r;
  state_e        state_nxt_s;
  logic          ptr_r;
  logic          issue_ok_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          accept_s;
  logic [DW-1:0] op_a_s;
  logic [DW-1:0] op_b_s;
  logic [3:0]    op_fun_s;
  logic [TW-1:0] op_tag_s;
  logic [DW-1:0] alu_data_s;
  logic          alu_zero_s;
  logic          alu_illegal_s;

  // Grant: ptr_r names the lane that wins the next contention.
  always_comb begin
    issue_ok_s = 1'b0;
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    if (reset)                      issue_ok_s = 1'b0;
    else if (state_r == ST_EMPTY)   issue_ok_s = 1'b1;
    else                            issue_ok_s = res_ready;
    if (issue_ok_s && req0_valid && req1_valid) begin
      grant0_s = ~ptr_r;
      grant1_s = ptr_r;
    end else if (issue_ok_s) begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign res_valid  = (state_r == ST_FULL);

  // Operand mux onto the shared ALU.
  always_comb begin
    op_a_s   = req0_a;
    op_b_s   = req0_b;
    op_fun_s = req0_fun;
    op_tag_s = req0_tag;
    if (grant1_s) begin
      op_a_s   = req1_a;
      op_b_s   = req1_b;
      op_fun_s = req1_fun;
      op_tag_s = req1_tag;
    end else begin
      op_a_s   = req0_a;
      op_b_s   = req0_b;
      op_fun_s = req0_fun;
      op_tag_s = req0_tag;
    end
  end

  alu_core #(.DW(DW)) u_alu_core (
    .a       (op_a_s),
    .b       (op_b_s),
    .fun     (op_fun_s),
    .data    (alu_data_s),
    .zero    (alu_zero_s),
    .illegal (alu_illegal_s)
  );

  // Result-stage next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_nxt_s = ST_FULL;
        else          state_nxt_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept_s)       state_nxt_s = ST_FULL;
        else if (res_ready) state_nxt_s = ST_EMPTY;
        else                state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Result-stage state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_EMPTY;
    else       state_r <= state_nxt_s;
  end

  // Result payload and round-robin pointer; both move only on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data    <= {DW{1'b0}};
      res_zero    <= 1'b0;
      res_lane    <= 1'b0;
      res_tag     <= {TW{1'b0}};
      res_illegal <= 1'b0;
      ptr_r       <= 1'b0;
    end else if (accept_s) begin
      res_data    <= alu_data_s;
      res_zero    <= alu_zero_s;
      res_lane    <= grant1_s;
      res_tag     <= op_tag_s;
      res_illegal <= alu_illegal_s;
      ptr_r       <= ~grant1_s;
    end
  end

  // Saturating per-lane acceptance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_lane0 <= 16'h0000;
      ops_lane1 <= 16'h0000;
    end else begin
      if (grant0_s && (ops_lane0 != 16'hFFFF)) ops_lane0 <= ops_lane0 + 16'h0001;
      if (grant1_s && (ops_lane1 != 16'hFFFF)) ops_lane1 <= ops_lane1 + 16'h0001;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: an ALU vector table plus hand-written
// arbitration, back-pressure, reset and counter-saturation sequences.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int TW = 3;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_fun, req1_fun;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          res_valid, res_ready, res_zero, res_lane, res_illegal;
  logic [DW-1:0] res_data;
  logic [TW-1:0] res_tag;
  logic [15:0]   ops_lane0, ops_lane1;

  int n_vec = 0;
  int n_bad = 0;

  alu_arbiter #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_lane(res_lane), .res_tag(res_tag),
    .res_illegal(res_illegal), .ops_lane0(ops_lane0), .ops_lane1(ops_lane1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          lane;
    logic [TW-1:0] tag;
    logic [3:0]    fun;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_data;
    logic          exp_zero;
    logic          exp_ill;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input logic lane, input logic v, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [3:0] fun, input logic [TW-1:0] tag);
    if (lane == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_fun = fun; req0_tag = tag;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_fun = fun; req1_tag = tag;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ops0;
  int exp_ops1;

  initial begin
    tbl[0]  = '{1'b0, 3'd3, 4'h0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 4'h1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 4'h2, 32'd1,         32'd32,        32'd0,         1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd4, 4'h2, 32'd1,         32'd4,         32'd16,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'd5, 4'h3, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0};
    tbl[5]  = '{1'b1, 3'd6, 4'h3, 32'hFFFF_FFFF, 32'd33,        32'd0,         1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd7, 4'h8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'd0, 4'h9, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'd1, 4'hA, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 4'hB, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'd3, 4'hC, 32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFF0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'd4, 4'hD, 32'd0,         32'd1,         32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 3'd5, 4'hE, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 3'd6, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0,         1'b1, 1'b0};
    tbl[14] = '{1'b0, 3'd7, 4'hF, 32'd1,         32'd2,         32'd0,         1'b0, 1'b0};
    tbl[15] = '{1'b1, 3'd0, 4'h5, 32'd9,         32'd9,         32'd0,         1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'd1, 4'h7, 32'd3,         32'd4,         32'd0,         1'b0, 1'b1};
    tbl[17] = '{1'b1, 3'd2, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0};

    reset = 1'b1; res_ready = 1'b0;
    set_lane(1'b0, 1'b1, 32'd1, 32'd1, 4'h0, 3'd1);
    set_lane(1'b1, 1'b1, 32'd2, 32'd2, 4'h0, 3'd2);
    tick();
    tick();
    check("rst_ready0", {63'd0, req0_ready}, 64'd0);
    check("rst_ready1", {63'd0, req1_ready}, 64'd0);
    check("rst_valid",  {63'd0, res_valid}, 64'd0);
    check("rst_data",   {32'd0, res_data}, 64'd0);
    check("rst_flags",  {60'd0, res_zero, res_lane, res_illegal, 1'b0}, 64'd0);
    check("rst_tag",    {61'd0, res_tag}, 64'd0);
    check("rst_ops",    {32'd0, ops_lane0, ops_lane1}, 64'd0);

    // ALU table: one lane valid per vector, consumer always ready.
    reset = 1'b0; res_ready = 1'b1;
    exp_ops0 = 0; exp_ops1 = 0;
    for (int i = 0; i < 18; i++) begin
      set_lane(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
      set_lane(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
      set_lane(tbl[i].lane, 1'b1, tbl[i].a, tbl[i].b, tbl[i].fun, tbl[i].tag);
      #1;
      check($sformatf("v%0d_ready0", i), {63'd0, req0_ready}, {63'd0, ~tbl[i].lane});
      check($sformatf("v%0d_ready1", i), {63'd0, req1_ready}, {63'd0, tbl[i].lane});
      if (tbl[i].lane) exp_ops1++; else exp_ops0++;
      tick();
      check($sformatf("v%0d_valid", i), {63'd0, res_valid}, 64'd1);
      check($sformatf("v%0d_data", i), {32'd0, res_data}, {32'd0, tbl[i].exp_data});
      check($sformatf("v%0d_zero", i), {63'd0, res_zero}, {63'd0, tbl[i].exp_zero});
      check($sformatf("v%0d_ill", i), {63'd0, res_illegal}, {63'd0, tbl[i].exp_ill});
      check($sformatf("v%0d_lane", i), {63'd0, res_lane}, {63'd0, tbl[i].lane});
      check($sformatf("v%0d_tag", i), {61'd0, res_tag}, {61'd0, tbl[i].tag});
    end
    check("tbl_ops0", {48'd0, ops_lane0}, 64'(exp_ops0));
    check("tbl_ops1", {48'd0, ops_lane1}, 64'(exp_ops1));

    // Drain with no request: FULL -> EMPTY.
    set_lane(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    set_lane(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    tick();
    check("drain_valid", {63'd0, res_valid}, 64'd0);

    // Back-pressure: hold result while consumer stalls, lane 1 waits.
    set_lane(1'b0, 1'b1, 32'd10, 32'd20, 4'h0, 3'd5);
    tick();
    check("bp_load_data", {32'd0, res_data}, 64'd30);
    set_lane(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    set_lane(1'b1, 1'b1, 32'd9, 32'd4, 4'h1, 3'd6);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready1", k), {63'd0, req1_ready}, 64'd0);
      check($sformatf("bp%0d_ready0", k), {63'd0, req0_ready}, 64'd0);
      tick();
      check($sformatf("bp%0d_valid", k), {63'd0, res_valid}, 64'd1);
      check($sformatf("bp%0d_data", k), {32'd0, res_data}, 64'd30);
      check($sformatf("bp%0d_lane_tag", k), {60'd0, res_lane, res_tag}, {60'd0, 1'b0, 3'd5});
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    check("bp_issue_data", {32'd0, res_data}, 64'd5);
    check("bp_issue_lane_tag", {60'd0, res_lane, res_tag}, {60'd0, 1'b1, 3'd6});

    // Reset while FULL discards the held result and clears counters.
    set_lane(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    set_lane(1'b0, 1'b1, 32'd7, 32'd7, 4'h0, 3'd4);
    tick();
    check("pre_rst_valid", {63'd0, res_valid}, 64'd1);
    res_ready = 1'b0; reset = 1'b1;
    set_lane(1'b1, 1'b1, 32'd1, 32'd1, 4'h0, 3'd1);
    #1;
    check("midrst_ready0", {63'd0, req0_ready}, 64'd0);
    check("midrst_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    check("midrst_valid", {63'd0, res_valid}, 64'd0);
    check("midrst_ops", {32'd0, ops_lane0, ops_lane1}, 64'd0);
    check("midrst_data", {32'd0, res_data}, 64'd0);
    reset = 1'b0; res_ready = 1'b1;
    set_lane(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    set_lane(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    tick();
    check("postrst_valid", {63'd0, res_valid}, 64'd0);

    // Contention: lane 0 wins first, then strict alternation.
    set_lane(1'b0, 1'b1, 32'd1, 32'd1, 4'h0, 3'd1);
    set_lane(1'b1, 1'b1, 32'd2, 32'd2, 4'h0, 3'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_ready0", k), {63'd0, req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_ready1", k), {63'd0, req1_ready}, (k % 2 == 1) ? 64'd1 : 64'd0);
      tick();
      check($sformatf("rr%0d_lane", k), {63'd0, res_lane}, (k % 2 == 1) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_data", k), {32'd0, res_data}, (k % 2 == 1) ? 64'd4 : 64'd2);
    end
    check("rr_ops0", {48'd0, ops_lane0}, 64'd2);
    check("rr_ops1", {48'd0, ops_lane1}, 64'd2);

    // Counter saturation on lane 0.
    set_lane(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 3'd0);
    repeat (65540) @(posedge clk);
    #1;
    check("sat_ops0", {48'd0, ops_lane0}, 64'h0000_0000_0000_FFFF);
    check("sat_ops1", {48'd0, ops_lane1}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
